dzmcu_oam_dma: RTL and testbench
================================

# dzmcu_oam_dma

Memory control unit sitting directly downstream of the dzcpu memory port. It decodes CPU accesses, serves high RAM (FF80–FFFE) and the DMA register (FF46) internally, and forwards all other accesses to the external memory port. It also runs the OAM DMA engine, which copies 160 bytes from page `XX00` to `FE00`. While DMA is active, the CPU is restricted to HRAM only.

## Interface
Parameters:
- `DMA_LEN`, 160: bytes per OAM transfer
- `OAM_BASE`, 16'hFE00: DMA destination base

Ports:
- `iClock` in 1: system clock.
- `iReset` in 1: reset, asynchronous, active-low.
- `iCpuAddr` in 16: CPU address (dzcpu `oMCUAddr`).
- `iCpuData` in 8: CPU write data (dzcpu `oMCUData`).
- `iCpuWe` in 1: CPU write strobe (dzcpu `oMCUwe`).
- `oCpuData` out 8: CPU read data (to dzcpu `iMCUData`); combinational.
- `oMemAddr` out 16: external memory address.
- `oMemData` out 8: external memory write data.
- `oMemWe` out 1: external memory write enable.
- `iMemData` in 8: external memory read data; combinational (asynchronous read).
- `oDmaBusy` out 1: high while a DMA transfer is in progress.

## Operation
- Address decode:
  - HRAM: `iCpuAddr` in FF80–FFFE.
  - DMAREG: `iCpuAddr` == FF46.
  - EXT: all other addresses.
- CPU reads:
  - HRAM → HRAM byte.
  - DMAREG → last value written.
  - EXT → `iMemData` when idle; 8'hFF while busy.
- CPU writes take effect on the clock edge with `iCpuWe`=1:
  - HRAM: always honored, including during DMA.
  - DMAREG: latches the page into `rDmaPage` and starts DMA.
  - EXT: forwarded (`oMemWe`=1) only when idle; dropped while busy.
- States:
  - IDLE → DMA_RD on a DMAREG write.
  - DMA_RD → DMA_WR always.
  - DMA_WR → IDLE when `idx`==`DMA_LEN`-1; otherwise `idx`+1 and → DMA_RD.
- DMA_RD: `oMemAddr`={`rDmaPage`,`idx`}, `oMemWe`=0. `iMemData` is latched into `rDmaByte` at the cycle end.
- DMA_WR: `oMemAddr`=`OAM_BASE`+`idx`, `oMemData`=`rDmaByte`, `oMemWe`=1.
- IDLE: `oMemAddr`=`iCpuAddr`, `oMemData`=`iCpuData`.
- `idx` is 8-bit, 0..159, and is cleared on every DMA start. The source page is used verbatim, with no remapping of E0–FF.
- DMAREG write while busy: restart. `rDmaPage` takes the new value, `idx`=0, next state DMA_RD. The in-flight DMA_WR (if any) still completes in that cycle.
- `oDmaBusy` = (state != IDLE).

## Timing
- Reset (`iReset`=0, asynchronous):
  - state=IDLE, `idx`=0, `rDmaPage`=0, `rDmaByte`=0.
  - `oMemWe`=0 and `oDmaBusy`=0 while reset is asserted.
  - `oMemAddr` follows `iCpuAddr`; `oCpuData` follows decode.
  - HRAM contents are not reset; after power-up they are undefined.
- Reset mid-DMA aborts immediately. Partially copied OAM is left as is.
- CPU read latency: 0 cycles (combinational through decode mux).
- CPU write: committed at the same rising edge.
- DMA: write to FF46 at edge N. DMA_RD occupies cycle N..N+1, and `oDmaBusy` rises after edge N. The last DMA_WR ends at edge N+2·`DMA_LEN`. `oDmaBusy` is high for exactly 320 cycles.
- Byte k: read in cycle 2k, written in cycle 2k+1, relative to busy start.
- Simultaneous CPU EXT write and DMA: the CPU write is dropped and DMA owns the memory port.

## Structure
- Shared definitions header (with the existing aDefinitions.v constants):
  - HRAM base/limit (FF80/FFFE)
  - `DMA_REG_ADDR` FF46
  - `OAM_BASE`
  - `DMA_LEN`
  - state encodings `DMA_IDLE`/`DMA_RD`/`DMA_WR`
- Sub-module `dzmcu_hram`: 127×8 register file with one combinational read port and one synchronous write port, no reset.
- Top level holds the decoder, the FSM with `idx` counter, the `rDmaPage`/`rDmaByte` registers, and the output muxes.

## Test plan
- Write 8'h5A to FF80, then 8'hA5 to FFFE → reads return 5A/A5. No `oMemWe` pulse on either write.
- Idle write of 8'h33 to C000 → `oMemAddr`=C000, `oMemData`=33, `oMemWe`=1 for one cycle. Read of 0150 returns the `iMemData` model value.
- Write 8'hC1 to FF46 with a memory model holding byte=low address → reads C100..C19F, writes FE00..FE9F with data 00..9F. `oDmaBusy` is high for exactly 320 cycles, and FF46 reads return C1.
- During DMA: read of 0150 → FF; write to D000 dropped; write 8'h77 to FF90 then read back → 77.
- At byte 50, write 8'hD0 to FF46 → next read address D000, `idx` restarts, busy for 320 more cycles.
- Assert `iReset` low at byte 80 → `oDmaBusy` and `oMemWe` drop immediately. After release, state is IDLE and FF46 reads 00.

Source files
------------

// File: rtl/dzmcu_oam_dma_pkg.sv
// Shared definitions for the dzmcu memory control unit: address map,
// OAM DMA constants and DMA state encodings.
package dzmcu_oam_dma_pkg;

  localparam logic [15:0] HRAM_BASE        = 16'hFF80;
  localparam logic [15:0] HRAM_LIMIT       = 16'hFFFE;
  localparam logic [15:0] DMA_REG_ADDR     = 16'hFF46;
  localparam logic [15:0] OAM_BASE_DEFAULT = 16'hFE00;
  localparam int unsigned DMA_LEN_DEFAULT  = 160;
  localparam int unsigned HRAM_DEPTH       = 127;
  localparam int unsigned HRAM_AW          = 7;

  typedef enum logic [1:0] {
    DMA_IDLE = 2'd0,
    DMA_RD   = 2'd1,
    DMA_WR   = 2'd2
  } dma_state_e;

  // True when the address falls inside high RAM.
  function automatic logic is_hram(input logic [15:0] addr);
    return (addr >= HRAM_BASE) && (addr <= HRAM_LIMIT);
  endfunction

endpackage

// File: rtl/dzmcu_oam_dma_hram.sv
// High RAM: 127x8 register file, one combinational read port and one
// synchronous write port. Contents are not reset.
//   clk   - write clock
//   we    - write enable
//   waddr - write index (0..126)
//   wdata - write data
//   raddr - read index (0..126)
//   rdata - combinational read data
module dzmcu_oam_dma_hram
  import dzmcu_oam_dma_pkg::*;
(
  input  logic               clk,
  input  logic               we,
  input  logic [HRAM_AW-1:0] waddr,
  input  logic [7:0]         wdata,
  input  logic [HRAM_AW-1:0] raddr,
  output logic [7:0]         rdata
);

  logic [7:0] mem [HRAM_DEPTH];

  // Index 127 (FFFF) is never decoded as HRAM; guard it anyway.
  always_ff @(posedge clk) begin
    if (we && (waddr < HRAM_AW'(HRAM_DEPTH))) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = (raddr < HRAM_AW'(HRAM_DEPTH)) ? mem[raddr] : 8'hFF;

endmodule

// File: rtl/dzmcu_oam_dma.sv
// Memory control unit downstream of the dzcpu memory port. Decodes CPU
// accesses, serves HRAM and the DMA register locally, forwards the rest to
// the external memory port, and runs the 160-byte OAM DMA engine.
//   iClock/iReset        - clock, async active-low reset
//   iCpuAddr/Data/We     - CPU access; oCpuData is combinational read data
//   oMemAddr/Data/We     - external memory port (owned by DMA while busy)
//   iMemData             - external memory async read data
//   oDmaBusy             - DMA transfer in progress
module dzmcu_oam_dma
  import dzmcu_oam_dma_pkg::*;
#(
  parameter int unsigned DMA_LEN  = DMA_LEN_DEFAULT,
  parameter logic [15:0] OAM_BASE = OAM_BASE_DEFAULT
) (
  input  logic        iClock,
  input  logic        iReset,
  input  logic [15:0] iCpuAddr,
  input  logic [7:0]  iCpuData,
  input  logic        iCpuWe,
  output logic [7:0]  oCpuData,
  output logic [15:0] oMemAddr,
  output logic [7:0]  oMemData,
  output logic        oMemWe,
  input  logic [7:0]  iMemData,
  output logic        oDmaBusy
);

  dma_state_e state;
  logic [7:0] idx;
  logic [7:0] rDmaPage;
  logic [7:0] rDmaByte;

  logic       hit_hram_c;
  logic       hit_dma_c;
  logic       hit_ext_c;
  logic       dma_start_c;
  logic [7:0] hram_rdata;

  // Address decode.
  assign hit_hram_c  = is_hram(iCpuAddr);
  assign hit_dma_c   = (iCpuAddr == DMA_REG_ADDR);
  assign hit_ext_c   = !hit_hram_c && !hit_dma_c;
  assign dma_start_c = iCpuWe && hit_dma_c;
  assign oDmaBusy    = (state != DMA_IDLE);

  dzmcu_oam_dma_hram u_hram (
    .clk   (iClock),
    .we    (iReset && iCpuWe && hit_hram_c),
    .waddr (iCpuAddr[HRAM_AW-1:0]),
    .wdata (iCpuData),
    .raddr (iCpuAddr[HRAM_AW-1:0]),
    .rdata (hram_rdata)
  );

  // DMA engine; a DMA register write (re)starts from byte 0 in any state.
  always_ff @(posedge iClock or negedge iReset) begin
    if (!iReset) begin
      state    <= DMA_IDLE;
      idx      <= 8'd0;
      rDmaPage <= 8'd0;
      rDmaByte <= 8'd0;
    end else begin
      case (state)
        DMA_RD: begin
          rDmaByte <= iMemData;
          state    <= DMA_WR;
        end
        DMA_WR: begin
          if (idx == 8'(DMA_LEN - 1)) begin
            state <= DMA_IDLE;
          end else begin
            idx   <= idx + 8'd1;
            state <= DMA_RD;
          end
        end
        default: state <= DMA_IDLE;
      endcase
      if (dma_start_c) begin
        rDmaPage <= iCpuData;
        idx      <= 8'd0;
        state    <= DMA_RD;
      end
    end
  end

  // External port mux: CPU passthrough when idle, DMA owns it when busy.
  always_comb begin
    oMemAddr = iCpuAddr;
    oMemData = iCpuData;
    oMemWe   = iReset && iCpuWe && hit_ext_c;
    case (state)
      DMA_RD: begin
        oMemAddr = {rDmaPage, idx};
        oMemWe   = 1'b0;
      end
      DMA_WR: begin
        oMemAddr = OAM_BASE + 16'(idx);
        oMemData = rDmaByte;
        oMemWe   = iReset;
      end
      default: ;
    endcase
  end

  // CPU read mux; external reads float high while DMA is busy.
  always_comb begin
    oCpuData = oDmaBusy ? 8'hFF : iMemData;
    if (hit_hram_c) begin
      oCpuData = hram_rdata;
    end else if (hit_dma_c) begin
      oCpuData = rDmaPage;
    end
  end

endmodule

// File: tb/tb_dzmcu_oam_dma.sv
// Self-checking bench for dzmcu_oam_dma: scoreboard of expected external
// port reads/writes, plus direct CPU readback and busy-length checks.
module tb_dzmcu_oam_dma;

  logic        iClock;
  logic        iReset;
  logic [15:0] iCpuAddr;
  logic [7:0]  iCpuData;
  logic        iCpuWe;
  logic [7:0]  oCpuData;
  logic [15:0] oMemAddr;
  logic [7:0]  oMemData;
  logic        oMemWe;
  logic [7:0]  iMemData;
  logic        oDmaBusy;

  int checks   = 0;
  int failures = 0;
  int busy_total = 0;

  logic [31:0] wr_q[$];
  logic [31:0] rd_q[$];

  dzmcu_oam_dma dut (
    .iClock   (iClock),
    .iReset   (iReset),
    .iCpuAddr (iCpuAddr),
    .iCpuData (iCpuData),
    .iCpuWe   (iCpuWe),
    .oCpuData (oCpuData),
    .oMemAddr (oMemAddr),
    .oMemData (oMemData),
    .oMemWe   (oMemWe),
    .iMemData (iMemData),
    .oDmaBusy (oDmaBusy)
  );

  // Memory model: each byte holds its low address.
  assign iMemData = oMemAddr[7:0];

  initial iClock = 1'b0;
  always #5 iClock = ~iClock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Scoreboard monitor: every port write and every DMA read is expected.
  always @(negedge iClock) begin
    logic [31:0] e;
    if (iReset) begin
      if (oDmaBusy) busy_total++;
      if (oMemWe) begin
        e = (wr_q.size() != 0) ? wr_q.pop_front() : 32'hDEAD_0000;
        check("mem_wr", {8'h00, oMemAddr, oMemData}, e);
      end else if (oDmaBusy) begin
        e = (rd_q.size() != 0) ? rd_q.pop_front() : 32'hDEAD_0000;
        check("dma_rd", {16'h0000, oMemAddr}, e);
      end
    end
  end

  task automatic cpu_write(input logic [15:0] a, input logic [7:0] d);
    @(posedge iClock); #1;
    iCpuAddr = a; iCpuData = d; iCpuWe = 1'b1;
    @(posedge iClock); #1;
    iCpuWe = 1'b0; iCpuAddr = 16'h0000;
  endtask

  task automatic cpu_read(input string tag, input logic [15:0] a, input logic [7:0] exp);
    @(posedge iClock); #1;
    iCpuAddr = a; iCpuWe = 1'b0;
    #1 check(tag, {24'h0, oCpuData}, {24'h0, exp});
  endtask

  task automatic push_dma(input logic [7:0] page, input int nrd, input int nwr);
    for (int k = 0; k < nrd; k++) rd_q.push_back({16'h0000, page, 8'(k)});
    for (int k = 0; k < nwr; k++) wr_q.push_back({8'h00, 16'hFE00 + 16'(k), 8'(k)});
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (oDmaBusy && n < 800) begin
      @(negedge iClock);
      n++;
    end
    check(tag, {31'h0, oDmaBusy}, 32'h0);
  endtask

  task automatic wait_read_addr(input string tag, input logic [15:0] a);
    int n;
    n = 0;
    do begin
      @(negedge iClock);
      n++;
    end while (!(oDmaBusy && !oMemWe && oMemAddr == a) && n < 800);
    check(tag, {16'h0, oMemAddr}, {16'h0, a});
  endtask

  initial begin
    int b0;
    iReset = 1'b0; iCpuAddr = 16'h1234; iCpuData = 8'h00; iCpuWe = 1'b0;
    #12;
    check("rst_busy", {31'h0, oDmaBusy}, 32'h0);
    check("rst_we", {31'h0, oMemWe}, 32'h0);
    check("rst_addr", {16'h0, oMemAddr}, 32'h0000_1234);
    @(posedge iClock); #1 iReset = 1'b1; iCpuAddr = 16'h0000;

    cpu_read("dmareg_rst", 16'hFF46, 8'h00);

    // HRAM boundaries
    cpu_write(16'hFF80, 8'h5A);
    cpu_write(16'hFFFE, 8'hA5);
    cpu_read("hram_lo", 16'hFF80, 8'h5A);
    cpu_read("hram_hi", 16'hFFFE, 8'hA5);

    // Idle external access
    wr_q.push_back({8'h00, 16'hC000, 8'h33});
    cpu_write(16'hC000, 8'h33);
    cpu_read("ext_rd", 16'h0150, 8'h50);

    // Full DMA from page C1 with CPU traffic during it
    push_dma(8'hC1, 160, 160);
    b0 = busy_total;
    cpu_write(16'hFF46, 8'hC1);
    cpu_read("busy_ext_rd", 16'h0150, 8'hFF);
    cpu_write(16'hD000, 8'h99);
    cpu_write(16'hFF90, 8'h77);
    cpu_read("busy_hram", 16'hFF90, 8'h77);
    cpu_read("busy_dmareg", 16'hFF46, 8'hC1);
    wait_idle("dma1_done");
    check("dma1_len", 32'(busy_total - b0), 32'd320);
    cpu_read("dmareg_c1", 16'hFF46, 8'hC1);

    // Restart at byte 50 with page D0
    push_dma(8'hC1, 51, 50);
    push_dma(8'hD0, 160, 160);
    b0 = busy_total;
    cpu_write(16'hFF46, 8'hC1);
    wait_read_addr("reach_b50", 16'hC132);
    #1 iCpuAddr = 16'hFF46; iCpuData = 8'hD0; iCpuWe = 1'b1;
    @(posedge iClock); #1 iCpuWe = 1'b0; iCpuAddr = 16'h0000;
    wait_idle("dma2_done");
    check("dma2_len", 32'(busy_total - b0), 32'd421);
    cpu_read("dmareg_d0", 16'hFF46, 8'hD0);

    // Reset at byte 80
    push_dma(8'hC1, 81, 80);
    cpu_write(16'hFF46, 8'hC1);
    wait_read_addr("reach_b80", 16'hC150);
    #1 iReset = 1'b0;
    #1;
    check("rst_mid_busy", {31'h0, oDmaBusy}, 32'h0);
    check("rst_mid_we", {31'h0, oMemWe}, 32'h0);
    @(posedge iClock); #1 iReset = 1'b1;
    check("post_rst_busy", {31'h0, oDmaBusy}, 32'h0);
    cpu_read("post_rst_dmareg", 16'hFF46, 8'h00);

    repeat (3) @(posedge iClock);
    check("wr_q_empty", 32'(wr_q.size()), 32'd0);
    check("rd_q_empty", 32'(rd_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
